// File: rtl/seq_stream_tx_pkg.sv
// seq_stream_tx_pkg: shared types and constants for the serial stimulus
// transmitter and its optional expected-z reference model.
// Optional feature macro: SEQ_STREAM_TX_EXPZ_EN (reference model + z_exp).
package seq_stream_tx_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Transmitter burst states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } txState_e;

    // Detector model states: A reset, B one 0, C 0s run, D one 1, E 1s run
    typedef enum logic [2:0] {
        MDL_A = 3'd0,
        MDL_B = 3'd1,
        MDL_C = 3'd2,
        MDL_D = 3'd3,
        MDL_E = 3'd4
    } mdlState_e;

endpackage

// File: rtl/seq_stream_tx_if.sv
// seq_stream_tx_if: burst handshake and serial output bundle of the
// transmitter. z_exp exists only when SEQ_STREAM_TX_EXPZ_EN is defined.
interface seq_stream_tx_if
    import seq_stream_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             step;
    logic             w;
    logic             busy;
    logic             done;
    logic [LW-1:0]    bit_cnt;
`ifdef SEQ_STREAM_TX_EXPZ_EN
    logic             z_exp;

    modport master (output start, pattern, len, step,
                    input  w, busy, done, bit_cnt, z_exp);
    modport slave  (input  start, pattern, len, step,
                    output w, busy, done, bit_cnt, z_exp);
`else
    modport master (output start, pattern, len, step,
                    input  w, busy, done, bit_cnt);
    modport slave  (input  start, pattern, len, step,
                    output w, busy, done, bit_cnt);
`endif
endinterface

// File: rtl/seq_ref_model.sv
// seq_ref_model: 5-state run detector mirroring the lab detectors. z is high
// after two or more equal consecutive bits. Used under SEQ_STREAM_TX_EXPZ_EN.
module seq_ref_model
    import seq_stream_tx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_valid,
    output logic z
);
    localparam logic [2:0] ST_A = MDL_A;
    localparam logic [2:0] ST_B = MDL_B;
    localparam logic [2:0] ST_C = MDL_C;
    localparam logic [2:0] ST_D = MDL_D;
    localparam logic [2:0] ST_E = MDL_E;

    logic [2:0] stateReg;
    logic [2:0] stateNext;

    // Next state: a 0 moves toward B/C, a 1 toward D/E
    always_comb begin
        stateNext = stateReg;
        if (bit_valid) begin
            if (bit_in)
                stateNext = (stateReg == ST_D || stateReg == ST_E) ? ST_E : ST_D;
            else
                stateNext = (stateReg == ST_B || stateReg == ST_C) ? ST_C : ST_B;
        end
    end

    // State register, advanced only on consumed bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stateReg <= ST_A;
        else
            stateReg <= stateNext;
    end

    assign z = (stateReg == ST_C) || (stateReg == ST_E);

endmodule

// File: rtl/seq_stream_tx.sv
// seq_stream_tx: loads a parallel pattern and sends it MSB-first (bit len-1
// first) on w, one bit per step strobe, framed by start/busy/done.
// Optional feature macro: SEQ_STREAM_TX_EXPZ_EN adds the reference model
// driving z_exp.
module seq_stream_tx
    import seq_stream_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LW    = $clog2(WIDTH + 1)
)(
    input logic             clk,
    input logic             reset,
    seq_stream_tx_if.slave  bus
);
    localparam logic [1:0] IDLE  = TX_IDLE;
    localparam logic [1:0] SHIFT = TX_SHIFT;
    localparam logic [1:0] DONE  = TX_DONE;

    logic [1:0]       stateReg;
    logic [WIDTH-1:0] shiftReg;
    logic [LW-1:0]    remCnt;
    logic [LW-1:0]    bitCntReg;
    logic             busyReg;
    logic             doneReg;
    logic             lenOk;
    logic             bitTaken;

    assign lenOk    = (bus.len != '0) && (bus.len <= LW'(WIDTH));
    assign bitTaken = (stateReg == SHIFT) && bus.step;

    // Burst FSM: load, shift one bit per step, one-cycle done, back to idle.
    // The head bit is not shifted out on the last step so w keeps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            shiftReg  <= '0;
            remCnt    <= '0;
            bitCntReg <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.start && lenOk) begin
                        stateReg  <= SHIFT;
                        shiftReg  <= bus.pattern << (LW'(WIDTH) - bus.len);
                        remCnt    <= bus.len;
                        bitCntReg <= '0;
                        busyReg   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.step) begin
                        bitCntReg <= bitCntReg + LW'(1);
                        remCnt    <= remCnt - LW'(1);
                        if (remCnt == LW'(1)) begin
                            stateReg <= DONE;
                            busyReg  <= 1'b0;
                            doneReg  <= 1'b1;
                        end else begin
                            shiftReg <= shiftReg << 1;
                        end
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                    doneReg  <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.w       = shiftReg[WIDTH-1];
    assign bus.busy    = busyReg;
    assign bus.done    = doneReg;
    assign bus.bit_cnt = bitCntReg;

`ifdef SEQ_STREAM_TX_EXPZ_EN
    seq_ref_model u_refModel (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (shiftReg[WIDTH-1]),
        .bit_valid (bitTaken),
        .z         (bus.z_exp)
    );
`else
    logic unusedBitTaken;
    assign unusedBitTaken = bitTaken;
`endif

endmodule

// File: tb/tb_seq_stream_tx.sv
// tb_seq_stream_tx: directed bench for seq_stream_tx. z_exp checks are
// compiled in when SEQ_STREAM_TX_EXPZ_EN is defined.
module tb_seq_stream_tx;
    import seq_stream_tx_pkg::*;

    logic clk;
    logic reset;
    int   checkCnt;
    int   passCnt;

    seq_stream_tx_if busIf ();

    seq_stream_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) begin
            passCnt++;
            $display("check %-14s got %0h exp %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startBurst(input logic [15:0] pat, input logic [4:0] n, input logic stp);
        busIf.pattern = pat;
        busIf.len     = n;
        busIf.start   = 1'b1;
        busIf.step    = stp;
        tick();
        busIf.start   = 1'b0;
    endtask

    logic [7:0] wB3;
    logic [7:0] zB3;
    logic [3:0] wA;
    int         bitIdx;

    initial begin
        checkCnt = 0;
        passCnt  = 0;
        wB3 = 8'b1011_0011;
        zB3 = 8'b0001_0101;
        wA  = 4'b1010;
        busIf.start   = 1'b0;
        busIf.pattern = '0;
        busIf.len     = '0;
        busIf.step    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        checkVal("rst_w", 32'(busIf.w), 32'd0);
        checkVal("rst_busy", 32'(busIf.busy), 32'd0);
        checkVal("rst_done", 32'(busIf.done), 32'd0);
        checkVal("rst_bitcnt", 32'(busIf.bit_cnt), 32'd0);
`ifdef SEQ_STREAM_TX_EXPZ_EN
        checkVal("rst_z", 32'(busIf.z_exp), 32'd0);
`endif

        // 0x00B3, len 8, step held high
        startBurst(16'h00B3, 5'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkVal($sformatf("b3_w%0d", i), 32'(busIf.w), 32'(wB3[7-i]));
            checkVal($sformatf("b3_busy%0d", i), 32'(busIf.busy), 32'd1);
            checkVal($sformatf("b3_done%0d", i), 32'(busIf.done), 32'd0);
            tick();
`ifdef SEQ_STREAM_TX_EXPZ_EN
            checkVal($sformatf("b3_z%0d", i), 32'(busIf.z_exp), 32'(zB3[7-i]));
`endif
        end
        checkVal("b3_done", 32'(busIf.done), 32'd1);
        checkVal("b3_busyoff", 32'(busIf.busy), 32'd0);
        checkVal("b3_bitcnt", 32'(busIf.bit_cnt), 32'd8);
        checkVal("b3_whold", 32'(busIf.w), 32'd1);
        tick();
        checkVal("b3_done_1cyc", 32'(busIf.done), 32'd0);
        checkVal("b3_widle", 32'(busIf.w), 32'd1);

        // 0xA, len 4, one strobe every third cycle
        startBurst(16'h000A, 5'd4, 1'b0);
        bitIdx = 0;
        for (int c = 0; c < 12; c++) begin
            busIf.step = (c % 3 == 2);
            checkVal($sformatf("slow_w%0d", c), 32'(busIf.w), 32'(wA[3-bitIdx]));
            checkVal($sformatf("slow_busy%0d", c), 32'(busIf.busy), 32'd1);
            tick();
            if (c % 3 == 2) bitIdx++;
        end
        busIf.step = 1'b0;
        checkVal("slow_done", 32'(busIf.done), 32'd1);
        checkVal("slow_bitcnt", 32'(busIf.bit_cnt), 32'd4);
        tick();

        // Invalid lengths leave everything untouched
        startBurst(16'hFFFF, 5'd0, 1'b1);
        checkVal("len0_busy", 32'(busIf.busy), 32'd0);
        checkVal("len0_w", 32'(busIf.w), 32'd0);
        checkVal("len0_bitcnt", 32'(busIf.bit_cnt), 32'd4);
        startBurst(16'hFFFF, 5'd17, 1'b1);
        checkVal("len17_busy", 32'(busIf.busy), 32'd0);
        checkVal("len17_w", 32'(busIf.w), 32'd0);
        checkVal("len17_bitcnt", 32'(busIf.bit_cnt), 32'd4);
        tick();
        checkVal("len17_done", 32'(busIf.done), 32'd0);

        // Full width burst with a start pulse in the middle
        startBurst(16'hFFFF, 5'd16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                busIf.start   = 1'b1;
                busIf.pattern = 16'h0000;
                busIf.len     = 5'd3;
            end else begin
                busIf.start = 1'b0;
            end
            checkVal($sformatf("ff_w%0d", i), 32'(busIf.w), 32'd1);
            checkVal($sformatf("ff_busy%0d", i), 32'(busIf.busy), 32'd1);
            tick();
        end
        busIf.start = 1'b0;
        checkVal("ff_done", 32'(busIf.done), 32'd1);
        checkVal("ff_bitcnt", 32'(busIf.bit_cnt), 32'd16);
        tick();
        checkVal("ff_idle_busy", 32'(busIf.busy), 32'd0);

        // Reset after 3 of 8 bits
        startBurst(16'h00B3, 5'd8, 1'b1);
        tick();
        tick();
        tick();
        checkVal("ab_bitcnt3", 32'(busIf.bit_cnt), 32'd3);
        reset = 1'b1;
        #1;
        checkVal("ab_busy", 32'(busIf.busy), 32'd0);
        checkVal("ab_w", 32'(busIf.w), 32'd0);
        checkVal("ab_bitcnt", 32'(busIf.bit_cnt), 32'd0);
        checkVal("ab_done", 32'(busIf.done), 32'd0);
`ifdef SEQ_STREAM_TX_EXPZ_EN
        checkVal("ab_z", 32'(busIf.z_exp), 32'd0);
`endif
        #1;
        reset = 1'b0;
        tick();
        checkVal("ab_nodone", 32'(busIf.done), 32'd0);
        checkVal("ab_idle", 32'(busIf.busy), 32'd0);

        // New burst after the abort runs normally, model restarted from A
        startBurst(16'h00B3, 5'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkVal($sformatf("re_w%0d", i), 32'(busIf.w), 32'(wB3[7-i]));
            tick();
`ifdef SEQ_STREAM_TX_EXPZ_EN
            checkVal($sformatf("re_z%0d", i), 32'(busIf.z_exp), 32'(zB3[7-i]));
`endif
        end
        checkVal("re_done", 32'(busIf.done), 32'd1);
        checkVal("re_bitcnt", 32'(busIf.bit_cnt), 32'd8);
        tick();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
